psum_pool: RTL and testbench



---
 rtl/psum_pool_pkg.sv | 20 ++
 rtl/psum_pool_quant.sv | 23 ++
 rtl/psum_pool.sv | 154 +++++++++++++++
 tb/tb_psum_pool.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pool_pkg.sv
// Shared CNN parameters: psum buffer geometry and default pooling stage
// widths, plus the classification of an incoming beat.
package psum_pool_pkg;

  localparam int unsigned PSUM_DATA_W    = 25;
  localparam int unsigned POOL_OUT_W     = 8;
  localparam int unsigned CONV_ROW_LEN   = 60;
  localparam int unsigned CONV_COL_LEN   = 60;
  localparam int unsigned PSUM_BUF_DEPTH = CONV_ROW_LEN * CONV_COL_LEN;
  localparam int unsigned PSUM_BUF_ADDR_W = $clog2(PSUM_BUF_DEPTH);

  typedef enum logic [2:0] {
    BEAT_IDLE,  // no valid input this cycle
    BEAT_HOLD,  // even column: capture into horizontal register
    BEAT_PAIR,  // odd column, even row: horizontal max into line buffer
    BEAT_POOL,  // odd column, odd row: full 2x2 max, emit output
    BEAT_PASS   // bypass: quantize the beat directly
  } beat_e;

endpackage

// File: rtl/psum_pool_quant.sv
// POOL_QUANT: logical right shift followed by unsigned saturation to OUT_W.
module psum_pool_quant #(
  parameter int unsigned DATA_W = 25,
  parameter int unsigned OUT_W  = 8
) (
  input  logic [DATA_W-1:0] m_i,
  input  logic [4:0]        shift_i,
  output logic [OUT_W-1:0]  q_o
);

  logic [DATA_W-1:0] shifted;

  assign shifted = m_i >> shift_i;

  generate
    if (DATA_W > OUT_W) begin : g_sat
      assign q_o = (|shifted[DATA_W-1:OUT_W]) ? '1 : shifted[OUT_W-1:0];
    end else begin : g_fit
      assign q_o = OUT_W'(shifted);
    end
  endgenerate

endmodule

// File: rtl/psum_pool.sv
// 2x2 max pool over a streamed conv output plane, with quantization.
// Optional PSUM_POOL_BYPASS_EN adds pool_bypass for per-beat pass-through.
module psum_pool
  import psum_pool_pkg::*;
#(
  parameter int unsigned DATA_W  = PSUM_DATA_W,
  parameter int unsigned OUT_W   = POOL_OUT_W,
  parameter int unsigned ROW_LEN = CONV_ROW_LEN,
  parameter int unsigned COL_LEN = CONV_COL_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              frame_start,
  input  logic [4:0]        shift_amt,
`ifdef PSUM_POOL_BYPASS_EN
  input  logic              pool_bypass,
`endif
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  output logic              out_last
);

  localparam int unsigned HALF = ROW_LEN / 2;
  localparam int unsigned CW   = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int unsigned RW   = (COL_LEN > 1) ? $clog2(COL_LEN) : 1;
  localparam int unsigned LW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(ROW_LEN - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(COL_LEN - 1);

  logic [CW-1:0]     col_q, col_d, col_eff;
  logic [RW-1:0]     row_q, row_d, row_eff;
  logic [DATA_W-1:0] h_q, h_d;
  logic [DATA_W-1:0] lbuf_q [HALF];
  logic [LW-1:0]     lbuf_idx;
  logic              lbuf_we;
  logic [DATA_W-1:0] din_r, pair_max, pool_max, quant_in;
  logic [OUT_W-1:0]  quant_out;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_last_q, out_last_d;
  logic              col_last, row_last, fire;
  beat_e             beat;

  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? '0 : v;
  endfunction

  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // frame_start zeroes the position seen by this very beat, not just the next one.
  always_comb begin
    col_eff  = frame_start ? '0 : col_q;
    row_eff  = frame_start ? '0 : row_q;
    col_last = (col_eff == COL_MAX);
    row_last = (row_eff == ROW_MAX);
    lbuf_idx = LW'(col_eff >> 1);
    din_r    = relu(in_data);
    pair_max = smax(h_q, din_r);
    pool_max = smax(pair_max, lbuf_q[lbuf_idx]);

    beat = BEAT_IDLE;
    if (in_valid) begin
`ifdef PSUM_POOL_BYPASS_EN
      if (pool_bypass)
        beat = BEAT_PASS;
      else
`endif
      if (!col_eff[0])
        beat = BEAT_HOLD;
      else if (!row_eff[0])
        beat = BEAT_PAIR;
      else
        beat = BEAT_POOL;
    end
  end

  always_comb begin
    col_d      = col_eff;
    row_d      = row_eff;
    h_d        = h_q;
    lbuf_we    = 1'b0;
    fire       = 1'b0;
    quant_in   = din_r;
    out_data_d = out_data_q;
    out_last_d = 1'b0;

    if (in_valid) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_eff + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
      end
    end

    unique case (beat)
      BEAT_HOLD: h_d = din_r;
      BEAT_PAIR: lbuf_we = 1'b1;
      BEAT_POOL: begin
        fire     = 1'b1;
        quant_in = pool_max;
      end
      BEAT_PASS: fire = 1'b1;
      default: ;
    endcase

    if (fire) begin
      out_data_d = quant_out;
      out_last_d = col_last && row_last;
    end
  end

  psum_pool_quant #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_quant (
    .m_i     (quant_in),
    .shift_i (shift_amt),
    .q_o     (quant_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      h_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      h_q         <= h_d;
      out_data_q  <= out_data_d;
      out_valid_q <= fire;
      out_last_q  <= out_last_d;
    end
  end

  // Even rows rewrite every entry before an odd row reads it, so no reset here.
  always_ff @(posedge clk) begin
    if (lbuf_we && !rst)
      lbuf_q[lbuf_idx] <= pair_max;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_psum_pool.sv
// Scoreboard bench for psum_pool on a 4x4 plane: stimulus pushes expectations
// from a frame-array reference model, a negedge monitor pops and compares.
module tb_psum_pool;

  localparam int DW = 25;
  localparam int OW = 8;
  localparam int RL = 4;
  localparam int CL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          frame_start;
  logic [4:0]    shift_amt;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
`ifdef PSUM_POOL_BYPASS_EN
  logic          pool_bypass;
`endif

  psum_pool #(
    .DATA_W  (DW),
    .OUT_W   (OW),
    .ROW_LEN (RL),
    .COL_LEN (CL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .frame_start (frame_start),
    .shift_amt   (shift_amt),
`ifdef PSUM_POOL_BYPASS_EN
    .pool_bypass (pool_bypass),
`endif
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     data;
    bit     last;
    longint cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  int pix[CL][RL];
  int pr = 0;
  int pc = 0;
  bit byp = 1'b0;
  int sh = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int quant(input int m);
    int q;
    q = m >> sh;
    return (q > (1 << OW) - 1) ? (1 << OW) - 1 : q;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Reference: keep the whole plane; every odd/odd position closes a 2x2 window.
  task automatic model(input int v, input bit fs);
    int   r;
    int   m;
    exp_t e;
    r = (v < 0) ? 0 : v;
    if (fs) begin
      pr = 0;
      pc = 0;
    end
    pix[pr][pc] = r;
    if (byp || (pr % 2 == 1 && pc % 2 == 1)) begin
      m = byp ? r : max4(pix[pr-1][pc-1], pix[pr-1][pc], pix[pr][pc-1], pix[pr][pc]);
      e.data = quant(m);
      e.last = (pr == CL - 1) && (pc == RL - 1);
      e.cyc  = cyc + 1;
      sbq.push_back(e);
    end
    if (pc == RL - 1) begin
      pc = 0;
      pr = (pr == CL - 1) ? 0 : pr + 1;
    end else begin
      pc++;
    end
  endtask

  task automatic send(input int v, input bit fs, input bit rs);
    in_data     = DW'(v);
    in_valid    = 1'b1;
    frame_start = fs;
    rst         = rs;
    if (rs) begin
      pr = 0;
      pc = 0;
    end else begin
      model(v, fs);
    end
    @(negedge clk);
    in_valid    = 1'b0;
    frame_start = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    pr = 0;
    pc = 0;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_shift(input int s);
    sh        = s;
    shift_amt = 5'(s);
  endtask

  function automatic int rand_val();
    logic [DW-1:0] t;
    int            sel;
    sel = int'($urandom_range(0, 3));
    t   = DW'($urandom);
    if (sel == 0) return -int'($urandom_range(1, 100000));
    if (sel == 1) return int'($signed(t));
    return int'($urandom_range(0, 1000));
  endfunction

  bit prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (!byp) check("no_back_to_back", longint'(prev_v), 0);
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got out_data %0d with empty scoreboard (cycle %0d)",
                 out_data, cyc);
      end else begin
        e = sbq.pop_front();
        check("out_data", longint'(out_data), longint'(e.data));
        check("out_last", longint'(out_last), longint'(e.last));
        check("out_latency", cyc, e.cyc);
      end
    end else if (out_last) begin
      check("out_last_without_valid", longint'(out_last), 0);
    end
    prev_v = out_valid;
  end

  int s27[16] = '{1, 5, 2, 3, 4, 0, 9, 1, 7, 7, 7, 7, 8, 6, 6, 6};
  int sneg[16] = '{-5, -1, -7, -9, -3, -2, -4, -6, -8, -1, -2, -3, -4, -5, -6, -7};

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    frame_start = 1'b0;
    in_data     = '0;
    set_shift(0);
`ifdef PSUM_POOL_BYPASS_EN
    pool_bypass = 1'b0;
`endif
    idle(3);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_last", longint'(out_last), 0);
    check("reset_out_data", longint'(out_data), 0);
    rst = 1'b0;
    idle(2);

    // Directed reference plane
    for (int i = 0; i < 16; i++) send(s27[i], i == 0, 1'b0);
    idle(3);

    // Saturation, then the same window scaled down
    for (int i = 0; i < 16; i++) send(300, i == 0, 1'b0);
    idle(2);
    set_shift(2);
    for (int i = 0; i < 16; i++) send(300, i == 0, 1'b0);
    idle(2);
    set_shift(0);

    // Negative operands clamp to zero
    for (int i = 0; i < 16; i++) send(sneg[i], i == 0, 1'b0);
    idle(2);

    // Random idle gaps between beats
    for (int i = 0; i < 16; i++) begin
      send(s27[i], i == 0, 1'b0);
      idle(int'($urandom_range(0, 3)));
    end
    idle(2);

    // Reset lands on the first odd/odd beat, then recover
    for (int i = 0; i < 6; i++) send(s27[i] + 50, i == 0, i == 5);
    idle(1);
    pulse_frame_start();
    for (int i = 0; i < 16; i++) send(s27[i], 1'b0, 1'b0);
    idle(2);

    // Random frames
    for (int f = 0; f < 6; f++) begin
      bit sep;
      set_shift(int'($urandom_range(0, 20)));
      sep = 1'($urandom_range(0, 1));
      if (sep) pulse_frame_start();
      for (int i = 0; i < 16; i++) begin
        send(rand_val(), !sep && i == 0, 1'b0);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      end
      idle(2);
    end
    set_shift(0);

`ifdef PSUM_POOL_BYPASS_EN
    byp         = 1'b1;
    pool_bypass = 1'b1;
    for (int i = 0; i < 16; i++) send(i + 1, i == 0, 1'b0);
    idle(3);
    pool_bypass = 1'b0;
    byp         = 1'b0;
`endif

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", longint'(sbq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
